fmadd_norm_round_seq: RTL and testbench

- Post-addition normaliser and rounder for the FMADD addition lane.
- Consumes the aligned-and-added sum mantissa, exponent, sign and guard/round/sticky bits from exponent matching plus the adder.
- Normalises iteratively: one right shift on carry-out, or multi-cycle left shifts by leading-zero chunks.
- Then rounds per RISC-V rounding mode and emits a packed result under a valid/ready handshake.

---
 rtl/fmadd_norm_round_seq_pkg.sv | 33 +++
 rtl/fmadd_norm_round_seq_round_decide.sv | 25 ++
 rtl/fmadd_norm_round_seq.sv | 227 ++++++++++++++++++++++
 tb/tb_fmadd_norm_round_seq.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/fmadd_norm_round_seq_pkg.sv
// Shared types for the FMADD addition-lane normaliser/rounder:
// FSM state encodings and RISC-V rounding-mode codes.
package fmadd_norm_round_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        RNE = 3'b000,
        RTZ = 3'b001,
        RDN = 3'b010,
        RUP = 3'b011,
        RMM = 3'b100
    } rm_e;

    // Reserved encodings 101..111 fall back to round-to-nearest-even.
    function automatic rm_e sanitize_rm(input logic [2:0] rm);
        rm_e r;
        case (rm)
            3'b001:  r = RTZ;
            3'b010:  r = RDN;
            3'b011:  r = RUP;
            3'b100:  r = RMM;
            default: r = RNE;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/fmadd_norm_round_seq_round_decide.sv
// Rounding increment decision shared by the FPU lanes: given sign, mode,
// fraction LSB, round bit and sticky, says whether to add one ulp.
module fmadd_round_decide
    import fmadd_norm_round_seq_pkg::*;
(
    input  logic       sign,
    input  logic [2:0] rm,
    input  logic       lsb,
    input  logic       rg,
    input  logic       rs,
    output logic       increment
);

    always_comb begin
        increment = 1'b0;
        case (rm)
            RTZ:     increment = 1'b0;
            RDN:     increment = sign & (rg | rs);
            RUP:     increment = ~sign & (rg | rs);
            RMM:     increment = rg;
            default: increment = rg & (rs | lsb);
        endcase
    end

endmodule

// File: rtl/fmadd_norm_round_seq.sv
// Iterative post-add normaliser and rounder for the FMADD addition lane.
// Optional macro FMADD_NORM_FLAGS_EN adds the registered out_fflags port.
module fmadd_norm_round_seq
    import fmadd_norm_round_seq_pkg::*;
#(
    parameter int std        = 31,
    parameter int man        = 22,
    parameter int exp        = 7,
    parameter int SHIFT_STEP = 8
) (
    input  logic                 clk,
    input  logic                 rst_l,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_sign,
    input  logic [exp:0]         in_exp,
    input  logic [2*man+4:0]     in_mant,
    input  logic                 in_guard,
    input  logic                 in_round,
    input  logic                 in_sticky,
    input  logic                 in_eff_sub,
    input  logic [2:0]           in_rm,
    output logic                 out_valid,
    input  logic                 out_ready,
`ifdef FMADD_NORM_FLAGS_EN
    output logic [4:0]           out_fflags,
`endif
    output logic [std:0]         out_result
);

    localparam int MW   = 2*man + 5;
    localparam int NPOS = 2*man + 3;
    localparam int EW   = exp + 3;
    localparam logic signed [EW-1:0] ONE_E   = EW'(1);
    localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << (exp + 1)) - 1);

    state_e                 state_q, state_d;
    logic                   sign_q, sign_d;
    logic signed [EW-1:0]   exp_q, exp_d;
    logic [MW-1:0]          mant_q, mant_d;
    logic                   g_q, g_d;
    logic                   r_q, r_d;
    logic                   sticky_q, sticky_d;
    logic                   sub_q, sub_d;
    rm_e                    rm_q, rm_d;
    logic                   zero_q, zero_d;
    logic                   out_valid_q, out_valid_d;
    logic [std:0]           out_result_q, out_result_d;

    // Left-shift distance for this NORM cycle: leading zeros below the carry,
    // capped by the per-cycle step and by how far the exponent can drop.
    int                     lz;
    int                     shamt;
    logic [NPOS+2:0]        ext_shifted;

    always_comb begin
        lz = NPOS + 1;
        for (int i = 0; i <= NPOS; i++) begin
            if (mant_q[i]) lz = NPOS - i;
        end
        shamt = lz;
        if (shamt > SHIFT_STEP) shamt = SHIFT_STEP;
        if (shamt > int'(exp_q) - 1) shamt = int'(exp_q) - 1;
        ext_shifted = {mant_q[NPOS:0], g_q, r_q} << shamt;
    end

    logic [man:0]           frac;
    logic                   hidden;
    logic                   rg;
    logic                   rs;
    logic                   inc;
    logic [man+2:0]         sum;
    logic signed [EW-1:0]   exp_rnd;
    logic                   overflow;
    logic                   exact_zero;
    logic                   zero_sign;
    logic                   inf_sel;
    logic [std:0]           result;

    assign frac   = mant_q[NPOS-1 -: man+1];
    assign hidden = mant_q[NPOS];
    assign rg     = mant_q[NPOS-man-2];
    assign rs     = (|mant_q[NPOS-man-3:0]) | g_q | r_q | sticky_q;

    fmadd_round_decide u_round_decide (
        .sign      (sign_q),
        .rm        (rm_q),
        .lsb       (frac[0]),
        .rg        (rg),
        .rs        (rs),
        .increment (inc)
    );

    // A denormal that rounds into the hidden bit becomes the smallest normal.
    always_comb begin
        sum        = {1'b0, hidden, frac} + (man+3)'(inc);
        exp_rnd    = hidden ? (exp_q + (sum[man+2] ? ONE_E : '0))
                            : (sum[man+1] ? ONE_E : '0);
        overflow   = (exp_rnd >= EXP_MAX);
        exact_zero = zero_q & ~sticky_q;
        zero_sign  = sub_q ? (rm_q == RDN) : sign_q;
        inf_sel    = (rm_q == RNE) | (rm_q == RMM) |
                     ((rm_q == RUP) & ~sign_q) | ((rm_q == RDN) & sign_q);
        if (overflow) begin
            result = inf_sel ? {sign_q, {(exp+1){1'b1}}, {(man+1){1'b0}}}
                             : {sign_q, {exp{1'b1}}, 1'b0, {(man+1){1'b1}}};
        end else if (exact_zero) begin
            result = {zero_sign, {(std){1'b0}}};
        end else begin
            result = {sign_q, exp_rnd[exp:0], sum[man:0]};
        end
    end

    always_comb begin
        state_d      = state_q;
        sign_d       = sign_q;
        exp_d        = exp_q;
        mant_d       = mant_q;
        g_d          = g_q;
        r_d          = r_q;
        sticky_d     = sticky_q;
        sub_d        = sub_q;
        rm_d         = rm_q;
        zero_d       = zero_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d   = in_sign;
                    exp_d    = $signed({2'b00, in_exp});
                    mant_d   = in_mant;
                    g_d      = in_guard;
                    r_d      = in_round;
                    sticky_d = in_sticky;
                    sub_d    = in_eff_sub;
                    rm_d     = sanitize_rm(in_rm);
                    zero_d   = 1'b0;
                    state_d  = NORM;
                end
            end
            NORM: begin
                if (mant_q == '0 && !g_q && !r_q) begin
                    zero_d  = 1'b1;
                    state_d = ROUND;
                end else if (mant_q[MW-1]) begin
                    mant_d   = {1'b0, mant_q[MW-1:1]};
                    g_d      = mant_q[0];
                    r_d      = g_q;
                    sticky_d = sticky_q | r_q;
                    exp_d    = exp_q + ONE_E;
                    state_d  = ROUND;
                end else if (mant_q[NPOS] || exp_q <= ONE_E) begin
                    state_d = ROUND;
                end else begin
                    mant_d = {1'b0, ext_shifted[NPOS+2:2]};
                    g_d    = ext_shifted[1];
                    r_d    = ext_shifted[0];
                    exp_d  = exp_q - EW'(shamt);
                end
            end
            ROUND: begin
                out_result_d = result;
                out_valid_d  = 1'b1;
                state_d      = DONE;
            end
            default: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q      <= IDLE;
            sign_q       <= 1'b0;
            exp_q        <= '0;
            mant_q       <= '0;
            g_q          <= 1'b0;
            r_q          <= 1'b0;
            sticky_q     <= 1'b0;
            sub_q        <= 1'b0;
            rm_q         <= RNE;
            zero_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
        end else begin
            state_q      <= state_d;
            sign_q       <= sign_d;
            exp_q        <= exp_d;
            mant_q       <= mant_d;
            g_q          <= g_d;
            r_q          <= r_d;
            sticky_q     <= sticky_d;
            sub_q        <= sub_d;
            rm_q         <= rm_d;
            zero_q       <= zero_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
        end
    end

`ifdef FMADD_NORM_FLAGS_EN
    // Tininess is judged before rounding: hidden bit clear after normalising.
    logic [4:0] fflags_q;
    logic       nx;
    assign nx = rg | rs | overflow;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            fflags_q <= '0;
        end else if (state_q == ROUND) begin
            fflags_q <= {2'b00, overflow, ~hidden & nx, nx};
        end
    end

    assign out_fflags = fflags_q;
`endif

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;

endmodule

// File: tb/tb_fmadd_norm_round_seq.sv
// Scoreboard bench for fmadd_norm_round_seq (single float, default parameters).
module tb_fmadd_norm_round_seq;

    logic        clk = 1'b0;
    logic        rst_l;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [48:0] in_mant;
    logic        in_guard;
    logic        in_round;
    logic        in_sticky;
    logic        in_eff_sub;
    logic [2:0]  in_rm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
`ifdef FMADD_NORM_FLAGS_EN
    logic [4:0]  out_fflags;
`endif

    always #5 clk = ~clk;

    fmadd_norm_round_seq dut (
        .clk        (clk),
        .rst_l      (rst_l),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_mant    (in_mant),
        .in_guard   (in_guard),
        .in_round   (in_round),
        .in_sticky  (in_sticky),
        .in_eff_sub (in_eff_sub),
        .in_rm      (in_rm),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
`ifdef FMADD_NORM_FLAGS_EN
        .out_fflags (out_fflags),
`endif
        .out_result (out_result)
    );

    typedef struct {
        logic [31:0] res;
        logic [4:0]  flg;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [48:0] bit49(input int pos);
        logic [48:0] one;
        one = 49'd1;
        return one << pos;
    endfunction

    task automatic run_op(input string tag, input logic sg, input logic [7:0] e,
                          input logic [48:0] m, input logic g, input logic r,
                          input logic s, input logic sub, input logic [2:0] rm,
                          input logic [31:0] res, input logic [4:0] flg,
                          input int lat, input int hold);
        exp_t x;
        int   n;
        x.res = res;
        x.flg = flg;
        x.lat = lat;
        sb.push_back(x);
        @(negedge clk);
        chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
        out_ready  = (hold == 0);
        in_sign    = sg;
        in_exp     = e;
        in_mant    = m;
        in_guard   = g;
        in_round   = r;
        in_sticky  = s;
        in_eff_sub = sub;
        in_rm      = rm;
        in_valid   = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_mant  = 49'({$urandom(), $urandom()});
        in_exp   = 8'($urandom());
        in_rm    = 3'($urandom());
        in_sign  = ~sg;
        n = 1;
        while (out_valid !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        x = sb.pop_front();
        if (out_valid !== 1'b1) begin
            chk({tag, ".timeout"}, 64'(out_valid), 64'd1);
            return;
        end
        chk({tag, ".result"}, 64'(out_result), 64'(x.res));
        chk({tag, ".latency"}, 64'(n), 64'(x.lat));
`ifdef FMADD_NORM_FLAGS_EN
        chk({tag, ".fflags"}, 64'(out_fflags), 64'(x.flg));
`endif
        $display("op %-10s result=%08h expected=%08h latency=%0d", tag, out_result, x.res, n);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk({tag, ".hold_result"}, 64'(out_result), 64'(x.res));
            chk({tag, ".hold_in_ready"}, 64'(in_ready), 64'd0);
            chk({tag, ".hold_valid"}, 64'(out_valid), 64'd1);
        end
        if (hold > 0) begin
            @(negedge clk);
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        chk({tag, ".drained"}, {62'd0, out_valid, in_ready}, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen_valid;
        rst_l      = 1'b0;
        in_valid   = 1'b0;
        in_sign    = 1'b0;
        in_exp     = 8'd0;
        in_mant    = 49'd0;
        in_guard   = 1'b0;
        in_round   = 1'b0;
        in_sticky  = 1'b0;
        in_eff_sub = 1'b0;
        in_rm      = 3'd0;
        out_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.in_ready", 64'(in_ready), 64'd1);
        chk("rst.out_valid", 64'(out_valid), 64'd0);
        chk("rst.out_result", 64'(out_result), 64'd0);
        @(negedge clk);
        rst_l = 1'b1;

        run_op("one",      0, 8'd127, bit49(47), 0, 0, 0, 0, 3'd0, 32'h3F800000, 5'b00000, 3, 0);
        run_op("carry",    0, 8'd127, bit49(48) | bit49(47), 0, 0, 0, 0, 3'd0, 32'h40400000, 5'b00000, 3, 0);
        run_op("cancel",   0, 8'd127, bit49(30), 0, 0, 0, 1, 3'd0, 32'h37000000, 5'b00000, 6, 0);
        run_op("zero_rne", 1, 8'd127, 49'd0, 0, 0, 0, 1, 3'd0, 32'h00000000, 5'b00000, 3, 0);
        run_op("zero_rdn", 0, 8'd127, 49'd0, 0, 0, 0, 1, 3'd2, 32'h80000000, 5'b00000, 3, 0);
        run_op("ovf_rne",  0, 8'd254, bit49(48), 0, 0, 0, 0, 3'd0, 32'h7F800000, 5'b00101, 3, 0);
        run_op("ovf_rtz",  0, 8'd254, bit49(48), 0, 0, 0, 0, 3'd1, 32'h7F7FFFFF, 5'b00101, 3, 0);
        run_op("tie_hold", 0, 8'd127, bit49(47) | bit49(24) | bit49(23), 0, 0, 0, 0, 3'd0,
               32'h3F800002, 5'b00001, 3, 5);
        run_op("neg_rne",  1, 8'd127, bit49(47) | bit49(23), 0, 0, 0, 0, 3'd0, 32'hBF800000, 5'b00001, 3, 0);
        run_op("neg_rtz",  1, 8'd127, bit49(47) | bit49(23), 0, 0, 0, 0, 3'd1, 32'hBF800000, 5'b00001, 3, 0);
        run_op("neg_rdn",  1, 8'd127, bit49(47) | bit49(23), 0, 0, 0, 0, 3'd2, 32'hBF800001, 5'b00001, 3, 0);
        run_op("neg_rup",  1, 8'd127, bit49(47) | bit49(23), 0, 0, 0, 0, 3'd3, 32'hBF800000, 5'b00001, 3, 0);
        run_op("neg_rmm",  1, 8'd127, bit49(47) | bit49(23), 0, 0, 0, 0, 3'd4, 32'hBF800001, 5'b00001, 3, 0);
        run_op("frac_ovf", 0, 8'd127, (bit49(25) - 49'd1) << 23, 0, 0, 0, 0, 3'd3,
               32'h40000000, 5'b00001, 3, 0);
        run_op("denorm",   0, 8'd1, bit49(46), 0, 0, 0, 0, 3'd0, 32'h00400000, 5'b00000, 3, 0);
        run_op("den_limit", 0, 8'd3, bit49(40), 0, 0, 0, 0, 3'd0, 32'h00040000, 5'b00000, 4, 0);
        run_op("den_carry", 0, 8'd1, (bit49(24) - 49'd1) << 23, 0, 0, 0, 0, 3'd0,
               32'h00800000, 5'b00011, 3, 0);
        run_op("rm_resv",  0, 8'd127, bit49(47) | bit49(24) | bit49(23), 0, 0, 0, 0, 3'd7,
               32'h3F800002, 5'b00001, 3, 0);
        run_op("g_shift",  0, 8'd127, 49'd0, 1, 0, 0, 0, 3'd0, 32'h27800000, 5'b00000, 9, 0);

        // Reset while the cancellation operation is still normalising.
        @(negedge clk);
        in_sign    = 1'b0;
        in_exp     = 8'd127;
        in_mant    = bit49(30);
        in_guard   = 1'b0;
        in_round   = 1'b0;
        in_sticky  = 1'b0;
        in_eff_sub = 1'b1;
        in_rm      = 3'd0;
        in_valid   = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_l = 1'b0;
        #1;
        chk("midrst.out_valid", 64'(out_valid), 64'd0);
        chk("midrst.in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_l = 1'b1;
        seen_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) seen_valid = 1'b1;
        end
        chk("midrst.no_output", 64'(seen_valid), 64'd0);
        $display("op midrst     out_valid_seen=%0d", seen_valid);

        run_op("after_rst", 0, 8'd127, bit49(47), 0, 0, 0, 0, 3'd0, 32'h3F800000, 5'b00000, 3, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
